// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one FPU adder between N_REQ requesters.
// One op in flight: grant, issue, wait for done or timeout, then hold response until accepted.
module fpu_rr_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*32-1:0] req_op_a,
    input  logic [N_REQ*32-1:0] req_op_b,
    output logic [31:0]        fpu_op_a,
    output logic [31:0]        fpu_op_b,
    output logic               fpu_start,
    input  logic               fpu_done,
    input  logic [31:0]        fpu_result,
    input  logic [3:0]         fpu_status,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_data,
    output logic [3:0]         rsp_status,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [CntW-1:0] wait_cnt_q;
    logic [31:0]     op_a_q, op_b_q, rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [3:0]      rsp_status_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    int unsigned     scan_idx;
    logic            timeout_hit;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % N_REQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(scan_idx);
            end
        end
    end

    assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (!reset && gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d            = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (fpu_done || timeout_hit) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        op_a_q   <= req_op_a[32*int'(gnt_idx) +: 32];
                        op_b_q   <= req_op_b[32*int'(gnt_idx) +: 32];
                        rsp_id_q <= gnt_idx;
                        rr_ptr_q <= ID_W'((32'(gnt_idx) + 1) % N_REQ);
                    end
                end
                StIssue: wait_cnt_q <= '0;
                StWait: begin
                    wait_cnt_q <= wait_cnt_q + CntW'(1);
                    // Done has priority over a same-cycle timeout.
                    if (fpu_done) begin
                        rsp_data_q   <= fpu_result;
                        rsp_status_q <= {1'b0, fpu_status[2:0]};
                    end else if (timeout_hit) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= 4'b1000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign fpu_start  = (state_q == StIssue);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Self-checking bench for fpu_rr_scheduler: FPU model plus round-robin reference,
// randomized operands/latencies, timeout, backpressure and reset-in-flight scenarios.
module tb_fpu_rr_scheduler;

    localparam int N  = 4;
    localparam int TO = 64;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*32-1:0] req_op_a, req_op_b;
    logic [31:0]    fpu_op_a, fpu_op_b, fpu_result, rsp_data;
    logic           fpu_start, fpu_done, rsp_valid, rsp_ready, busy;
    logic [3:0]     fpu_status, rsp_status;
    logic [1:0]     rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    // FPU model controls
    int         fpu_lat  = 6;
    bit         fpu_en   = 1'b1;
    bit         fpu_keep = 1'b0;
    int         fpu_cnt  = 0;
    logic [3:0] fpu_st   = 4'h0;

    fpu_rr_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_start(fpu_start),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_status(fpu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy)
    );

    always #5 clock = ~clock;

    // FPU: done pulse fpu_lat cycles after the start cycle; result is integer a+b.
    initial begin
        fpu_done = 1'b0; fpu_result = '0; fpu_status = '0;
        forever begin
            @(negedge clock);
            fpu_done = 1'b0;
            if (reset && !fpu_keep) fpu_cnt = 0;
            if (fpu_cnt > 0) begin
                fpu_cnt--;
                if (fpu_cnt == 0) begin
                    fpu_done   = 1'b1;
                    fpu_result = fpu_op_a + fpu_op_b;
                    fpu_status = fpu_st;
                end
            end
            if (fpu_start && fpu_en) fpu_cnt = fpu_lat;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (mask[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_op_a = {$urandom, $urandom, $urandom, $urandom};
        req_op_b = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clock);
        n_checks++;
        if ({req_ready, fpu_start, rsp_valid, busy, fpu_op_a, fpu_op_b, rsp_id, rsp_data,
             rsp_status} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b st=%b v=%b busy=%b a=%h b=%h id=%0d d=%h s=%b expected all 0",
                     req_ready, fpu_start, rsp_valid, busy, fpu_op_a, fpu_op_b, rsp_id,
                     rsp_data, rsp_status);
        end
        reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL idle_no_req: got busy=%b rdy=%b expected 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_single();
        int cyc;
        apply_reset();
        fpu_en = 1'b1; fpu_lat = 6; fpu_st = 4'h0;
        req_op_a[31:0] = 32'h3E000000; req_op_b[31:0] = 32'h3E000000;
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        @(negedge clock);
        req_valid = '0;
        n_checks++;
        if (fpu_start !== 1'b1 || fpu_op_a !== 32'h3E000000 || fpu_op_b !== 32'h3E000000) begin
            n_fail++;
            $display("FAIL single_start: got start=%b a=%h b=%h expected 1/3e000000/3e000000",
                     fpu_start, fpu_op_a, fpu_op_b);
        end
        wait_rsp(200, cyc);
        n_checks++;
        if (cyc !== 7) begin
            n_fail++; $display("FAIL single_latency: got %0d expected 7", cyc);
        end
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 32'h7C000000 || rsp_status !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_rsp: got id=%0d d=%h s=%b expected 0/7c000000/0000",
                     rsp_id, rsp_data, rsp_status);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got busy=%b v=%b expected 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_all_valid();
        int ids[$];
        logic [31:0] dat[$];
        int cyc = 0;
        apply_reset();
        fpu_lat = 3; fpu_st = 4'h0;
        req_op_a = {$urandom, $urandom, $urandom, $urandom};
        req_op_b = {$urandom, $urandom, $urandom, $urandom};
        req_valid = '1; rsp_ready = 1'b1;
        while (ids.size() < 6 && cyc < 300) begin
            #1;
            n_checks++;
            if ($countones(req_ready) > 1) begin
                n_fail++; $display("FAIL onehot_ready: got %b expected at most one bit", req_ready);
            end
            if (rsp_valid === 1'b1) begin
                ids.push_back(int'(rsp_id));
                dat.push_back(rsp_data);
            end
            @(negedge clock);
            cyc++;
        end
        req_valid = '0; rsp_ready = 1'b0;
        n_checks++;
        if (ids.size() != 6) begin
            n_fail++; $display("FAIL rr_count: got %0d responses expected 6", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            n_checks++;
            if (ids[i] != i % N || dat[i] !== req_op_a[32*(i%N) +: 32] + req_op_b[32*(i%N) +: 32]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got id=%0d d=%h expected id=%0d d=%h", i, ids[i],
                         dat[i], i % N, req_op_a[32*(i%N) +: 32] + req_op_b[32*(i%N) +: 32]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pending = '0;
        logic [31:0]  ea[N], eb[N];
        int ptr = 0;
        int g, cyc;
        logic [3:0] st;
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pending[i] = 1'b1;
                    ea[i] = $urandom; eb[i] = $urandom;
                    req_op_a[32*i +: 32] = ea[i]; req_op_b[32*i +: 32] = eb[i];
                end
            end
            if (pending == '0) begin
                g = $urandom_range(0, N - 1);
                pending[g] = 1'b1;
                ea[g] = $urandom; eb[g] = $urandom;
                req_op_a[32*g +: 32] = ea[g]; req_op_b[32*g +: 32] = eb[g];
            end
            req_valid = pending;
            fpu_lat = $urandom_range(1, 12);
            st = 4'($urandom);
            fpu_st = st;
            g = rr_pick(pending, ptr);
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << g)) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %b expected %b", it, req_ready, 4'b0001 << g);
            end
            @(negedge clock);
            pending[g] = 1'b0;
            req_valid = pending;
            ptr = (g + 1) % N;
            wait_rsp(200, cyc);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== ea[g] + eb[g] ||
                rsp_status !== {1'b0, st[2:0]}) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got v=%b id=%0d d=%h s=%b expected 1/%0d/%h/%b",
                         it, rsp_valid, rsp_id, rsp_data, rsp_status, g, ea[g] + eb[g],
                         {1'b0, st[2:0]});
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            rsp_ready = 1'b1;
            @(negedge clock);
            rsp_ready = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int cyc;
        apply_reset();
        fpu_en = 1'b0;
        req_op_a[64 +: 32] = $urandom; req_op_b[64 +: 32] = $urandom;
        req_valid = 4'b0100;
        @(negedge clock);
        req_valid = '0;
        wait_rsp(TO + 50, cyc);
        n_checks++;
        if (cyc !== TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, TO + 1);
        end
        n_checks++;
        if (rsp_id !== 2'd2 || rsp_data !== 32'h0 || rsp_status !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_rsp: got id=%0d d=%h s=%b expected 2/00000000/1000",
                     rsp_id, rsp_data, rsp_status);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        fpu_en = 1'b1;
    endtask

    task automatic test_done_at_expiry();
        int cyc;
        logic [31:0] a, b;
        apply_reset();
        fpu_lat = TO; fpu_st = 4'b1111;
        a = $urandom; b = $urandom;
        req_op_a[96 +: 32] = a; req_op_b[96 +: 32] = b;
        req_valid = 4'b1000;
        @(negedge clock);
        req_valid = '0;
        wait_rsp(TO + 50, cyc);
        n_checks++;
        if (cyc !== TO + 1) begin
            n_fail++; $display("FAIL expiry_latency: got %0d expected %0d", cyc, TO + 1);
        end
        n_checks++;
        if (rsp_id !== 2'd3 || rsp_data !== a + b || rsp_status !== 4'b0111) begin
            n_fail++;
            $display("FAIL expiry_rsp: got id=%0d d=%h s=%b expected 3/%h/0111",
                     rsp_id, rsp_data, rsp_status, a + b);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] a1, b1, a3;
        apply_reset();
        fpu_lat = 2; fpu_st = 4'b0101;
        a1 = $urandom; b1 = $urandom; a3 = $urandom;
        req_op_a[32 +: 32] = a1; req_op_b[32 +: 32] = b1; req_op_a[96 +: 32] = a3;
        req_valid = 4'b0010;
        @(negedge clock);
        req_valid = '0;
        wait_rsp(50, cyc);
        req_valid = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== a1 + b1 ||
                rsp_status !== 4'b0101 || req_ready !== 4'b0000 || fpu_start !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b id=%0d d=%h s=%b rdy=%b st=%b expected 1/1/%h/0101/0000/0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_status, req_ready, fpu_start, a1 + b1);
            end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL after_hold: got v=%b rdy=%b expected 0/1000", rsp_valid, req_ready);
        end
        @(negedge clock);
        req_valid = '0;
        n_checks++;
        if (fpu_start !== 1'b1 || fpu_op_a !== a3) begin
            n_fail++;
            $display("FAIL next_issue: got st=%b a=%h expected 1/%h", fpu_start, fpu_op_a, a3);
        end
        wait_rsp(50, cyc);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        apply_reset();
        fpu_keep = 1'b1; fpu_lat = 8;
        req_op_a[64 +: 32] = $urandom; req_op_b[64 +: 32] = $urandom;
        req_valid = 4'b0100;
        @(negedge clock);
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({req_ready, fpu_start, rsp_valid, busy, fpu_op_a, fpu_op_b, rsp_id, rsp_data,
             rsp_status} !== '0) begin
            n_fail++;
            $display("FAIL wait_reset: got busy=%b v=%b a=%h b=%h id=%0d d=%h s=%b expected all 0",
                     busy, rsp_valid, fpu_op_a, fpu_op_b, rsp_id, rsp_data, rsp_status);
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0 || fpu_start !== 1'b0) begin
                n_fail++;
                $display("FAIL late_done[%0d]: got busy=%b v=%b st=%b expected 0/0/0",
                         i, busy, rsp_valid, fpu_start);
            end
        end
        fpu_keep = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL ptr_restart: got %b expected 0001", req_ready);
        end
        @(negedge clock);
        req_valid = '0;
        wait_rsp(50, cyc);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        req_valid = '0; rsp_ready = 1'b0; reset = 1'b1;
        req_op_a = '0; req_op_b = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_random();
        test_timeout();
        test_done_at_expiry();
        test_backpressure();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
